// File: rtl/adc_max10_pkg.sv
// ============================================================================
// adc_max10_pkg : register map, ADCS field positions and sequencer states
// Revision      : 1.0
// ============================================================================
`default_nettype none

package adc_max10_pkg;

  localparam int c_CH_COUNT_DEF   = 9;

  localparam int c_ADDR_ADCS      = 0;
  localparam int c_ADDR_ADMSK     = 1;
  localparam int c_ADDR_ADCD_BASE = 2;

  localparam int c_BIT_EN = 0;
  localparam int c_BIT_SC = 1;
  localparam int c_BIT_TE = 2;
  localparam int c_BIT_IE = 3;
  localparam int c_BIT_IF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_CMD    = 3'd2,
    ST_RESP   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/adc_max10_seq.sv
// ============================================================================
// adc_max10_seq : scan FSM issuing one single-beat command per enabled channel
// Revision      : 1.0
// ============================================================================
`default_nettype none

module adc_max10_seq
  import adc_max10_pkg::*;
#(
  parameter int CH_COUNT = c_CH_COUNT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_en,
  input  logic [CH_COUNT-1:0] i_mask,
  input  logic                i_c_ready,
  input  logic                i_r_valid,
  input  logic [11:0]         i_r_data,
  output logic                o_c_valid,
  output logic [4:0]          o_c_channel,
  output logic                o_res_we,
  output logic [4:0]          o_res_idx,
  output logic [11:0]         o_res_data,
  output logic                o_done,
  output logic                o_busy
);

  seq_state_t          r_state;
  logic [CH_COUNT-1:0] r_mask;
  logic [4:0]          r_idx;
  logic                r_c_valid;
  logic [4:0]          r_c_channel;
  logic                r_res_we;
  logic [4:0]          r_res_idx;
  logic [11:0]         r_res_data;
  logic                r_done;
  logic                r_busy;

  logic                w_found;
  logic [4:0]          w_sel;

  // Descending loop so the last hit is the lowest enabled channel >= r_idx.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = CH_COUNT - 1; i >= 0; i--) begin
      if (r_mask[i] && (5'(i) >= r_idx)) begin
        w_found = 1'b1;
        w_sel   = 5'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_idx       <= '0;
      r_c_valid   <= 1'b0;
      r_c_channel <= '0;
      r_res_we    <= 1'b0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_res_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mask  <= i_mask;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_found && i_en) begin
            r_c_valid   <= 1'b1;
            r_c_channel <= w_sel;
            r_idx       <= w_sel;
            r_state     <= ST_CMD;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_CMD: begin
          if (i_c_ready) begin
            r_c_valid <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_r_valid) begin
            r_res_we   <= 1'b1;
            r_res_idx  <= r_idx;
            r_res_data <= i_r_data;
            r_idx      <= r_idx + 5'd1;
            r_state    <= ST_SELECT;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_c_valid   = r_c_valid;
  assign o_c_channel = r_c_channel;
  assign o_res_we    = r_res_we;
  assign o_res_idx   = r_res_idx;
  assign o_res_data  = r_res_data;
  assign o_done      = r_done;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: rtl/adc_max10_ctrl.sv
// ============================================================================
// adc_max10_ctrl : register-mapped scan controller for the MAX10 modular ADC
// Revision       : 1.0
// ============================================================================
`default_nettype none

module adc_max10_ctrl
  import adc_max10_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int CH_COUNT   = c_CH_COUNT_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  output logic                  ADC_C_Valid,
  output logic [4:0]            ADC_C_Channel,
  output logic                  ADC_C_SOP,
  output logic                  ADC_C_EOP,
  input  logic                  ADC_C_Ready,
  input  logic                  ADC_R_Valid,
  input  logic [4:0]            ADC_R_Channel,
  input  logic [11:0]           ADC_R_Data,
  input  logic                  ADC_R_SOP,
  input  logic                  ADC_R_EOP,
  input  logic                  ADC_Trigger,
  output logic                  ADC_Interrupt
);

  logic                r_en;
  logic                r_sc;
  logic                r_te;
  logic                r_ie;
  logic                r_if;
  logic [CH_COUNT-1:0] r_admsk;
  logic [11:0]         r_adcd [CH_COUNT];
  logic                r_trig_d;

  logic                w_wr_adcs;
  logic                w_wr_admsk;
  logic                w_sw_start;
  logic                w_trig_start;
  logic                w_start;
  logic                w_seq_done;
  logic                w_seq_busy;
  logic                w_res_we;
  logic [4:0]          w_res_idx;
  logic [11:0]         w_res_data;
  logic                w_unused;

  assign w_wr_adcs  = write_enable && (write_addr == ADDR_WIDTH'(c_ADDR_ADCS));
  assign w_wr_admsk = write_enable && (write_addr == ADDR_WIDTH'(c_ADDR_ADMSK));

  // A software start uses the EN value carried by the same write.
  assign w_sw_start   = w_wr_adcs && write_data[c_BIT_SC] && write_data[c_BIT_EN];
  assign w_trig_start = ADC_Trigger && !r_trig_d && r_en && r_te;
  assign w_start      = (w_sw_start || w_trig_start) && !w_seq_busy;

  adc_max10_seq #(
    .CH_COUNT (CH_COUNT)
  ) u_seq (
    .clk         (CLK),
    .rst         (RESET),
    .i_start     (w_start),
    .i_en        (r_en),
    .i_mask      (r_admsk),
    .i_c_ready   (ADC_C_Ready),
    .i_r_valid   (ADC_R_Valid),
    .i_r_data    (ADC_R_Data),
    .o_c_valid   (ADC_C_Valid),
    .o_c_channel (ADC_C_Channel),
    .o_res_we    (w_res_we),
    .o_res_idx   (w_res_idx),
    .o_res_data  (w_res_data),
    .o_done      (w_seq_done),
    .o_busy      (w_seq_busy)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_en     <= 1'b0;
      r_sc     <= 1'b0;
      r_te     <= 1'b0;
      r_ie     <= 1'b0;
      r_if     <= 1'b0;
      r_admsk  <= '0;
      r_trig_d <= 1'b0;
      for (int i = 0; i < CH_COUNT; i++) begin
        r_adcd[i] <= '0;
      end
    end else begin
      r_trig_d <= ADC_Trigger;
      if (w_wr_adcs) begin
        r_en <= write_data[c_BIT_EN];
        r_te <= write_data[c_BIT_TE];
        r_ie <= write_data[c_BIT_IE];
      end
      if (w_start) begin
        r_sc <= 1'b1;
      end else if (w_seq_done) begin
        r_sc <= 1'b0;
      end
      // Hardware set takes priority over a simultaneous software clear.
      if (w_seq_done) begin
        r_if <= 1'b1;
      end else if (w_wr_adcs && !write_data[c_BIT_IF]) begin
        r_if <= 1'b0;
      end
      if (w_wr_admsk) begin
        r_admsk <= write_data[CH_COUNT-1:0];
      end
      for (int i = 0; i < CH_COUNT; i++) begin
        if (w_res_we && (w_res_idx == 5'(i))) begin
          r_adcd[i] <= w_res_data;
        end
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (read_addr == ADDR_WIDTH'(c_ADDR_ADCS)) begin
      read_data[c_BIT_EN] = r_en;
      read_data[c_BIT_SC] = r_sc;
      read_data[c_BIT_TE] = r_te;
      read_data[c_BIT_IE] = r_ie;
      read_data[c_BIT_IF] = r_if;
    end else if (read_addr == ADDR_WIDTH'(c_ADDR_ADMSK)) begin
      read_data[CH_COUNT-1:0] = r_admsk;
    end else begin
      for (int i = 0; i < CH_COUNT; i++) begin
        if (read_addr == ADDR_WIDTH'(c_ADDR_ADCD_BASE + i)) begin
          read_data[11:0] = r_adcd[i];
        end
      end
    end
  end

  assign ADC_C_SOP     = ADC_C_Valid;
  assign ADC_C_EOP     = ADC_C_Valid;
  assign ADC_Interrupt = r_if && r_ie;

  assign w_unused = ^{ADC_R_Channel, ADC_R_SOP, ADC_R_EOP, write_data};

endmodule

`default_nettype wire

// File: tb/tb_adc_max10_ctrl.sv
// ============================================================================
// tb_adc_max10_ctrl : randomized scoreboard bench with a behavioural ADC model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_adc_max10_ctrl;

  localparam int          NCH = 9;
  localparam logic [31:0] EN  = 32'h01;
  localparam logic [31:0] SC  = 32'h02;
  localparam logic [31:0] TE  = 32'h04;
  localparam logic [31:0] IE  = 32'h08;
  localparam logic [31:0] IFL = 32'h10;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;
  logic        ADC_R_SOP;
  logic        ADC_R_EOP;
  logic        ADC_Trigger;
  logic        ADC_Interrupt;

  adc_max10_ctrl #(
    .ADDR_WIDTH (4),
    .CH_COUNT   (NCH)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .ADC_C_Valid   (ADC_C_Valid),
    .ADC_C_Channel (ADC_C_Channel),
    .ADC_C_SOP     (ADC_C_SOP),
    .ADC_C_EOP     (ADC_C_EOP),
    .ADC_C_Ready   (ADC_C_Ready),
    .ADC_R_Valid   (ADC_R_Valid),
    .ADC_R_Channel (ADC_R_Channel),
    .ADC_R_Data    (ADC_R_Data),
    .ADC_R_SOP     (ADC_R_SOP),
    .ADC_R_EOP     (ADC_R_EOP),
    .ADC_Trigger   (ADC_Trigger),
    .ADC_Interrupt (ADC_Interrupt)
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  int          exp_cmd[$];
  int          pend[$];
  logic [11:0] adc_val  [NCH];
  logic [11:0] exp_adcd [NCH];
  logic        hold_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    write_addr   = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge CLK);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    read_addr = a;
    #1;
    chk(name, read_data, exp);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    read_addr = 4'd0;
    #1;
    while (read_data[1] === 1'b1 && n < 500) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk({name, "_timeout"}, (n >= 500) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic expect_scan(input logic [8:0] mask);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        exp_cmd.push_back(c);
        exp_adcd[c] = adc_val[c];
      end
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_queue_left"}, exp_cmd.size(), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      rd_chk($sformatf("%s_adcd%0d", tag, c), 4'(2 + c), {20'b0, exp_adcd[c]});
    end
  endtask

  // trig_mode: 0 software start, 1 trigger pulse, 2 trigger raised and left high
  task automatic run_scan(input logic [8:0] mask, input logic [31:0] ctl,
                          input int trig_mode, input string tag);
    bus_write(4'd1, {23'b0, mask});
    expect_scan(mask);
    bus_write(4'd0, ctl);
    if (trig_mode != 0) begin
      @(negedge CLK);
      ADC_Trigger = 1'b1;
      @(negedge CLK);
      if (trig_mode == 1) ADC_Trigger = 1'b0;
    end
    wait_idle(tag);
    rd_chk({tag, "_adcs"}, 4'd0, (ctl & (EN | TE | IE)) | IFL);
    chk({tag, "_irq"}, {31'b0, ADC_Interrupt}, {31'b0, ctl[3]});
    chk_results(tag);
  endtask

  // Scoreboard monitor: every accepted command must match the next expected channel.
  initial begin : monitor
    logic       hold_pend;
    logic [4:0] hold_ch;
    int         e;
    hold_pend = 1'b0;
    hold_ch   = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend)
          chk("cmd_hold", {26'b0, ADC_C_Valid, ADC_C_Channel}, {26'b0, 1'b1, hold_ch});
        hold_pend = 1'b0;
        if (ADC_C_Valid) begin
          chk("cmd_sop_eop", {30'b0, ADC_C_SOP, ADC_C_EOP}, 32'h3);
          if (ADC_C_Ready) begin
            if (exp_cmd.size() == 0) begin
              chk("cmd_unexpected", {27'b0, ADC_C_Channel}, 32'hFFFF_FFFF);
            end else begin
              e = exp_cmd.pop_front();
              chk("cmd_channel", {27'b0, ADC_C_Channel}, 32'(e));
            end
            pend.push_back(int'(ADC_C_Channel));
          end else begin
            hold_pend = 1'b1;
            hold_ch   = ADC_C_Channel;
          end
        end
      end
    end
  end

  // ADC IP model: random ready, one response per accepted command after a random delay.
  initial begin : adc_model
    int ch;
    ADC_C_Ready   = 1'b0;
    ADC_R_Valid   = 1'b0;
    ADC_R_Channel = '0;
    ADC_R_Data    = '0;
    ADC_R_SOP     = 1'b0;
    ADC_R_EOP     = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      ADC_R_Valid = 1'b0;
      if (RESET) pend.delete();
      ADC_C_Ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        ch            = pend.pop_front();
        ADC_R_Valid   = 1'b1;
        ADC_R_Channel = 5'(ch);
        ADC_R_Data    = adc_val[ch];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int n;
    RESET        = 1'b1;
    read_addr    = '0;
    write_addr   = '0;
    write_data   = '0;
    write_enable = 1'b0;
    ADC_Trigger  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      adc_val[c]  = '0;
      exp_adcd[c] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    chk("reset_c_valid", {31'b0, ADC_C_Valid}, 32'd0);
    chk("reset_irq", {31'b0, ADC_Interrupt}, 32'd0);
    for (int a = 0; a < 16; a++) rd_chk($sformatf("reset_reg%0d", a), 4'(a), 32'd0);

    bus_write(4'd1, 32'hFFFF_FFFF);
    rd_chk("admsk_readback", 4'd1, 32'h1FF);

    adc_val[0] = 12'h123;
    adc_val[2] = 12'hABC;
    run_scan(9'h005, EN | SC | IE, 0, "sw");
    bus_write(4'd0, EN | IE);
    chk("if_clear_irq", {31'b0, ADC_Interrupt}, 32'd0);
    rd_chk("if_clear_adcs", 4'd0, EN | IE);

    for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom_range(0, 4095));
    bus_write(4'd1, 32'h1FF);
    expect_scan(9'h1FF);
    bus_write(4'd0, 32'h1F);
    rd_chk("adcs_1f_readback", 4'd0, 32'h0F);
    wait_idle("adcs_1f");
    rd_chk("adcs_1f_done", 4'd0, 32'h1D);
    chk("adcs_1f_irq", {31'b0, ADC_Interrupt}, 32'd1);
    chk_results("adcs_1f");
    bus_write(4'd0, 32'h0);

    for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom_range(0, 4095));
    run_scan(9'h1FF, EN | TE, 2, "trig");
    repeat (20) @(posedge CLK);
    #1;
    rd_chk("trig_held_adcs", 4'd0, EN | TE | IFL);
    chk("trig_held_queue", exp_cmd.size(), 32'd0);
    ADC_Trigger = 1'b0;

    bus_write(4'd0, 32'h0);
    bus_write(4'd0, SC);
    rd_chk("disabled_adcs", 4'd0, 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    rd_chk("disabled_adcs_later", 4'd0, 32'd0);

    bus_write(4'd1, 32'h0);
    bus_write(4'd0, EN | SC);
    repeat (3) @(posedge CLK);
    #1;
    rd_chk("empty_adcs", 4'd0, EN | IFL);
    chk("empty_irq", {31'b0, ADC_Interrupt}, 32'd0);

    for (int it = 0; it < 8; it++) begin
      logic [31:0] ctl;
      logic [8:0]  mask;
      int          mode;
      mask = 9'($urandom_range(0, 511));
      mode = $urandom_range(0, 1);
      ctl  = EN | (($urandom_range(0, 1) == 1) ? IE : 32'h0) | ((mode == 1) ? TE : SC);
      for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom_range(0, 4095));
      run_scan(mask, ctl, mode, $sformatf("rand%0d", it));
    end

    hold_ready = 1'b1;
    bus_write(4'd1, 32'h1FF);
    bus_write(4'd0, EN | SC | IE);
    n = 0;
    while (ADC_C_Valid !== 1'b1 && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("rst_mid_valid_seen", {31'b0, ADC_C_Valid}, 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_mid_valid_drop", {31'b0, ADC_C_Valid}, 32'd0);
    RESET      = 1'b0;
    hold_ready = 1'b0;
    for (int a = 0; a < 16; a++) rd_chk($sformatf("rst_mid_reg%0d", a), 4'(a), 32'd0);
    chk("rst_mid_irq", {31'b0, ADC_Interrupt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_max10_ctrl.md
Name: adc_max10_ctrl

Overview:
Register-mapped controller for the Intel MAX10 modular ADC IP. It sequences single-sample conversions over a software-selected channel mask through the IP's Avalon-ST command/response interfaces, and stores each 12-bit result in a per-channel register. Scans start from software or from an external trigger, and the block raises an interrupt on scan completion. It sits between a bus-slave wrapper (simple read/write port) and the ADC IP core.

Parameters:
ADDR_WIDTH, 4, register address width
CH_COUNT, 9, number of ADC channels (channel numbers 0..CH_COUNT-1)

Ports:
CLK  in  1  system clock; ADC IP command/response side is synchronous to it
RESET  in  1  synchronous, active-high reset
read_addr  in  ADDR_WIDTH  register read address
read_data  out  32  combinational read data for read_addr
write_addr  in  ADDR_WIDTH  register write address
write_data  in  32  write data
write_enable  in  1  write strobe, sampled on the CLK rising edge
ADC_C_Valid  out  1  command valid
ADC_C_Channel  out  5  command channel number
ADC_C_SOP  out  1  command start-of-packet
ADC_C_EOP  out  1  command end-of-packet
ADC_C_Ready  in  1  command ready from IP
ADC_R_Valid  in  1  response valid
ADC_R_Channel  in  5  response channel (ignored)
ADC_R_Data  in  12  conversion result
ADC_R_SOP  in  1  ignored
ADC_R_EOP  in  1  ignored
ADC_Trigger  in  1  external scan trigger, synchronous to CLK
ADC_Interrupt  out  1  level interrupt

Behaviour:
- Register map (word index):
  - 0x0 ADCS
  - 0x1 ADMSK
  - 0x2+i ADCDi for i=0..CH_COUNT-1
  - All other addresses read 0 and ignore writes.
- ADCS fields, all reset 0:
  - bit0 EN: enable
  - bit1 SC: start / busy
  - bit2 TE: trigger enable
  - bit3 IE: interrupt enable
  - bit4 IF: interrupt flag
  - Other bits read 0.
- ADMSK: bits CH_COUNT-1:0 are the channel enables; upper bits read 0. Reset 0.
- ADCDi: bits 11:0 hold the last result for channel i, upper bits 0. Read-only. Reset 0.
- Writes take effect on the CLK edge where write_enable=1. Reads are combinational from current register state.
- ADCS write rules:
  - EN, TE, IE load directly from write_data.
  - SC: writing 1 requests a scan; writing 0 has no effect.
  - IF: writing 0 clears it; writing 1 has no effect.
  - If a hardware IF set and a software clear occur in the same cycle, the hardware set wins.
- Scan start:
  - SC request with EN=1 while IDLE starts a scan.
  - A rising edge of ADC_Trigger starts a scan when EN=1, TE=1 and the FSM is IDLE. Edge detection uses a 1-cycle registered copy of ADC_Trigger.
  - A start request with EN=0 is ignored and SC stays 0.
  - SC reads 1 from the cycle after a start until scan completion.
  - A start request during a scan is ignored.
- FSM states: IDLE, SELECT, CMD, RESP, DONE.
  - SELECT: find the lowest enabled channel at or above the scan index. If none, go to DONE.
  - CMD: drive ADC_C_Valid=1 and ADC_C_Channel=index. ADC_C_SOP and ADC_C_EOP equal ADC_C_Valid (single-beat packets). Hold all of these until ADC_C_Ready=1, then go to RESP.
  - RESP: on ADC_R_Valid=1, store ADC_R_Data into ADCD[index], increment index, go to SELECT.
  - DONE: clear SC, set IF, go to IDLE.
- The scan uses the ADMSK value latched at scan start. An empty mask goes straight to DONE, so IF is set with no commands issued.
- Clearing EN mid-scan: no new commands are issued; an in-flight response is still captured; then DONE. IF is still set in this case.
- ADC_Interrupt = IF & IE (combinational).
- Reset mid-scan: immediate return to IDLE, all registers 0, ADC_C_Valid=0 in the following cycle.
- All outputs reset to 0.

Decomposition:
- Package adc_max10_pkg holds:
  - register addresses: ADCS, ADMSK, ADCD base
  - ADCS field bit positions: EN, SC, TE, IE, IF
  - CH_COUNT default
  - FSM state enum
- One natural sub-module, adc_max10_seq: the scan FSM plus channel selection. The top level keeps the register file, trigger edge detection and read mux.

Test Plan:
- Reset: read every address -> 0. ADC_C_Valid=0, ADC_Interrupt=0.
- Mask write/readback:
  - Write ADMSK=0xFFFFFFFF -> reads 0x1FF.
  - Write ADCS=0x1F -> reads 0x0F (IF not settable by software).
- Software scan:
  - Setup: ADMSK=0x005, ADCS=EN|SC|IE, ADC model returns 0x123 for ch0 and 0xABC for ch2.
  - Required commands: exactly two, channel 0 then 2, each held until ready.
  - Required results: ADCD0=0x123, ADCD2=0xABC, ADCD1=0.
  - Completion: SC reads 0, IF=1, ADC_Interrupt=1.
  - Writing IF=0 then drops ADC_Interrupt.
- Trigger:
  - ADCS=EN|TE with ADMSK=0x1FF, pulse ADC_Trigger -> 9 commands, channels 0..8 in order, then IF=1, ADC_Interrupt stays 0 (IE=0).
  - Holding ADC_Trigger high afterwards starts no second scan.
- Disabled/empty:
  - SC with EN=0 -> no command, SC stays 0.
  - SC with EN=1 and ADMSK=0 -> IF set within 3 cycles, no command issued.
- Reset mid-scan: assert RESET while ADC_C_Valid=1 -> next cycle ADC_C_Valid=0, all registers 0.
